serial_unrotator: RTL
=====================

# serial_unrotator

Sequential left-rotator that reverses the right-rotation performed by the combinational mux-based barrel shifter. It accepts a rotated word and the rotation amount, rotates left one bit per clock, and returns the original word over a valid/ready handshake. It sits on the receive side of the barrel-shifter datapath and trades latency for area: one W-bit register and a small counter instead of W muxes.

## Interface

Parameters:
- WIDTH, 4, data word width in bits; must be a power of two and at least 2.
- AW, $clog2(WIDTH), width of the rotation amount.

Ports:
- clk  input  1  single clock; everything is rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  upstream offers in_data/in_amt.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  WIDTH  rotated word (right-rotated by in_amt).
- in_amt  input  AW  rotation amount to undo, 0..WIDTH-1.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  in_data rotated left by in_amt.
- busy  output  1  high in SHIFT or DONE.

## Operation

- Function: out_data = (in_data << in_amt) | (in_data >> (WIDTH - in_amt)). For amt 0 the output equals the input. Rotating right by s and then through this block with the same s returns the original word.
- FSM has three states: IDLE, SHIFT and DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: data_q<=in_data and cnt_q<=in_amt.
  - Next state is DONE if in_amt==0, otherwise SHIFT.
- SHIFT:
  - Each cycle: data_q<={data_q[WIDTH-2:0], data_q[WIDTH-1]} and cnt_q<=cnt_q-1.
  - On the cycle cnt_q==1 the last step is taken; next state is DONE.
- DONE:
  - out_valid=1, out_data=data_q.
  - Holds with out_data stable until out_ready=1, then returns to IDLE.
- in_valid is ignored outside IDLE. No new transaction is accepted in the same cycle DONE retires.
- Reset asserted mid-operation:
  - Immediately forces IDLE; data_q and cnt_q clear to 0.
  - The in-flight result is discarded and out_valid drops asynchronously.
- cnt_q is AW bits wide and never underflows, because SHIFT is only entered with cnt_q≥1.

## Timing

- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- Latency from the accept edge to out_valid high is in_amt+1 cycles (amt 0 → 1 cycle; amt WIDTH-1 → WIDTH cycles).
- out_valid and out_data are registered-state driven and glitch-free. in_ready and busy are decodes of the state register only, with no combinational path from inputs.
- Per transaction: accept, amt shift cycles, at least 1 DONE cycle, then at least 1 IDLE cycle before the next accept. Minimum period is amt+2 cycles.
- out_ready held low stalls indefinitely in DONE; data_q does not change while stalled.

## Structure

- Shared package barrel_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a localparam default WIDTH of 4;
  - a rotl function used as the reference model in the bench.
- Sub-module rotate_left_step: combinational one-position left rotate of WIDTH bits, instantiated once and feeding data_q's D input in SHIFT.
- Remaining logic is the FSM, counter and handshake, all in serial_unrotator.

## Test plan

- Reset then idle:
  - Stimulus: rst_n low, then high, with in_valid=0.
  - Required: in_ready=1, out_valid=0, out_data=4'b0000, busy=0, steady across 5 cycles.
- Single rotate:
  - Stimulus: in_data=4'b1000, in_amt=1, out_ready=1.
  - Required: out_valid rises 2 cycles after accept, out_data=4'b0001. Then in_ready=1 again.
- Full sweep against the barrel shifter:
  - Stimulus: for every w in 0..15 and s in 0..3, rotate w right by s and feed the result with amt=s.
  - Required: out_data==w every time, with latency s+1.
- Zero amount:
  - Stimulus: in_data=4'b1011, in_amt=0.
  - Required: out_valid the next cycle, out_data=4'b1011, no SHIFT cycles.
- Backpressure:
  - Stimulus: in_data=4'b0110, in_amt=3, out_ready low for 6 cycles after out_valid.
  - Required: out_data=4'b0011 held stable and in_ready=0 throughout. A second in_valid during the stall is not accepted.
- Mid-shift reset:
  - Stimulus: accept amt=3, then pulse rst_n low during the second SHIFT cycle.
  - Required: out_valid=0 and busy=0 immediately, in_ready=1 after release. The next transaction (4'b0100, amt=2) yields 4'b0001.

Source files
------------

// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared types, default width and rotate reference for the barrel datapath
package barrel_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [DEFAULT_WIDTH-1:0] rotl(
        input logic [DEFAULT_WIDTH-1:0] x,
        input int                       amt
    );
        logic [DEFAULT_WIDTH-1:0] r;
        r = x;
        for (int i = 0; i < DEFAULT_WIDTH; i++) begin
            if (i < amt) begin
                r = {r[DEFAULT_WIDTH-2:0], r[DEFAULT_WIDTH-1]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rotate_left_step.sv
// rtl/rotate_left_step.sv - combinational one-position left rotate
module rotate_left_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] rotated
);

    assign rotated = {data[WIDTH-2:0], data[WIDTH-1]};

endmodule

// File: rtl/serial_unrotator.sv
// rtl/serial_unrotator.sv - undoes a right rotation by rotating left one bit per clock
module serial_unrotator
    import barrel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] data_q;
    logic [AW-1:0]    cnt_q;
    logic [WIDTH-1:0] step_data;
    logic             accept;

    rotate_left_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data    (data_q),
        .rotated (step_data)
    );

    assign accept = in_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // cnt_q never wraps: SHIFT is only entered with a non-zero amount and left when it reaches 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            data_q <= in_data;
            cnt_q  <= in_amt;
        end else if (state_q == SHIFT) begin
            data_q <= step_data;
            cnt_q  <= cnt_q - AW'(1);
        end
    end

    assign out_data = data_q;

endmodule
